multicycle_control: RTL and testbench

Multicycle sequencer for the RV32I core's shared datapath (ALU, register bank, immediate generator, single unified memory port). It replaces the single-cycle combinational control decode with a registered FSM: one instruction is executed over 3–5 cycles, and each cycle asserts only the strobes that step needs. The memory port uses a req/ready handshake, so fetch and data access share one port and stall on slow memory. The block also counts retired instructions and traps on unsupported opcodes.

---
 rtl/multicycle_control.sv | 207 ++++++++++++++++++++
 tb/tb_multicycle_control.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// multicycle_control
//
// Registered sequencer for the RV32I shared datapath. Each instruction runs
// over 3-5 cycles; every cycle raises only the datapath strobes that step
// needs. Fetch and data access share one memory port.
//
// Memory handshake: mem_req is held high, with iord/mem_we steady, in every
// cycle of a FETCH/MEM_RD/MEM_WR step. The access completes in the cycle
// where mem_req and mem_ready are both high. mem_ready is ignored whenever
// mem_req is low.
//
// Ports
//   CLK, RESET      clock, synchronous active-high reset
//   opcode          IR[6:0], stable from DECODE on
//   mem_ready       memory completes this cycle's access
//   mem_req/mem_we/iord               memory port controls
//   ir_write/pc_write/pc_write_cond/pc_source   IR and PC update controls
//   alu_src_a/alu_src_b/alu_op        ALU operand and operation selects
//   reg_write/mem_to_reg              register writeback controls
//   illegal         sticky unsupported-opcode flag
//   state_o         current state encoding (debug)
//   retired         retired-instruction counter, n bits, wraps silently
module multicycle_control #(
    parameter int unsigned n = 32
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic [6:0]   opcode,
    input  logic         mem_ready,
    output logic         mem_req,
    output logic         mem_we,
    output logic         iord,
    output logic         ir_write,
    output logic         pc_write,
    output logic         pc_write_cond,
    output logic         pc_source,
    output logic [1:0]   alu_src_a,
    output logic [1:0]   alu_src_b,
    output logic [3:0]   alu_op,
    output logic         reg_write,
    output logic         mem_to_reg,
    output logic         illegal,
    output logic [3:0]   state_o,
    output logic [n-1:0] retired
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC_R = 4'd2,
        S_EXEC_I = 4'd3,
        S_ADDR   = 4'd4,
        S_MEM_RD = 4'd5,
        S_MEM_WR = 4'd6,
        S_WB_ALU = 4'd7,
        S_WB_MEM = 4'd8,
        S_BRANCH = 4'd9,
        S_TRAP   = 4'd10
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_RFN   = 4'b0010;
    localparam logic [3:0] ALU_IFN   = 4'b0011;

    state_t state;
    state_t state_next;
    logic   retire;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state   <= S_FETCH;
            illegal <= 1'b0;
            retired <= '0;
        end else begin
            state <= state_next;
            if (state_next == S_TRAP)
                illegal <= 1'b1;
            if (retire)
                retired <= retired + n'(1);
        end
    end

    // Next state and per-state strobes. RESET forces every strobe low so an
    // abandoned instruction cannot write anything in the reset cycle.
    always_comb begin
        state_next    = state;
        retire        = 1'b0;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        iord          = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = 1'b0;
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;
        alu_op        = ALU_ADD;
        reg_write     = 1'b0;
        mem_to_reg    = 1'b0;

        case (state)
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready)
                    state_next = S_DECODE;
            end
            S_DECODE: begin
                // Branch target (OldPC + Imm<<1) is parked in ALUOut here.
                alu_src_a = 2'b10;
                alu_src_b = 2'b11;
                case (opcode)
                    OP_R:               state_next = S_EXEC_R;
                    OP_I:               state_next = S_EXEC_I;
                    OP_LOAD, OP_STORE:  state_next = S_ADDR;
                    OP_BRANCH:          state_next = S_BRANCH;
                    default:            state_next = S_TRAP;
                endcase
            end
            S_EXEC_R: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b00;
                alu_op     = ALU_RFN;
                state_next = S_WB_ALU;
            end
            S_EXEC_I: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                alu_op     = ALU_IFN;
                state_next = S_WB_ALU;
            end
            S_ADDR: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                state_next = (opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (mem_ready)
                    state_next = S_WB_MEM;
            end
            S_MEM_WR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                iord    = 1'b1;
                if (mem_ready) begin
                    state_next = S_FETCH;
                    retire     = 1'b1;
                end
            end
            S_WB_ALU: begin
                reg_write  = 1'b1;
                state_next = S_FETCH;
                retire     = 1'b1;
            end
            S_WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_next = S_FETCH;
                retire     = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 2'b01;
                alu_src_b     = 2'b00;
                alu_op        = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = 1'b1;
                state_next    = S_FETCH;
                retire        = 1'b1;
            end
            S_TRAP: begin
                state_next = S_TRAP;
            end
            default: begin
                state_next = S_FETCH;
            end
        endcase

        if (RESET) begin
            mem_req       = 1'b0;
            mem_we        = 1'b0;
            iord          = 1'b0;
            ir_write      = 1'b0;
            pc_write      = 1'b0;
            pc_write_cond = 1'b0;
            pc_source     = 1'b0;
            alu_src_a     = 2'b00;
            alu_src_b     = 2'b00;
            alu_op        = ALU_ADD;
            reg_write     = 1'b0;
            mem_to_reg    = 1'b0;
        end
    end

    assign state_o = RESET ? 4'd0 : state;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control, built with a 4-bit retired counter
// so the wrap can be reached quickly. Every cycle the expected state and
// strobe vector is pushed when inputs are driven and popped at the falling
// edge for comparison.
module tb_multicycle_control;

  localparam int W = 21;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_L   = 7'b0000011;
  localparam logic [6:0] OP_S   = 7'b0100011;
  localparam logic [6:0] OP_B   = 7'b1100011;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  localparam logic [3:0] FETCH  = 4'd0;
  localparam logic [3:0] DECODE = 4'd1;
  localparam logic [3:0] EXEC_R = 4'd2;
  localparam logic [3:0] EXEC_I = 4'd3;
  localparam logic [3:0] ADDR   = 4'd4;
  localparam logic [3:0] MEM_RD = 4'd5;
  localparam logic [3:0] MEM_WR = 4'd6;
  localparam logic [3:0] WB_ALU = 4'd7;
  localparam logic [3:0] WB_MEM = 4'd8;
  localparam logic [3:0] BRANCH = 4'd9;
  localparam logic [3:0] TRAP   = 4'd10;

  logic       CLK;
  logic       RESET;
  logic [6:0] opcode;
  logic       mem_ready;
  logic       mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond, pc_source;
  logic [1:0] alu_src_a, alu_src_b;
  logic [3:0] alu_op;
  logic       reg_write, mem_to_reg, illegal;
  logic [3:0] state_o;
  logic [3:0] retired;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs;
  logic [3:0]   exp_retired;
  logic         exp_illegal;
  int           checks;
  int           fails;
  int           step;

  multicycle_control #(.n(4)) dut (
    .CLK(CLK), .RESET(RESET), .opcode(opcode), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .illegal(illegal),
    .state_o(state_o), .retired(retired)
  );

  assign obs = {state_o, mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond,
                pc_source, alu_src_a, alu_src_b, alu_op, reg_write, mem_to_reg};

  // clock
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Expected strobes for a state, written from the state table.
  function automatic logic [16:0] strobes(input logic [3:0] s, input logic r);
    logic mreq, mwe, io, irw, pcw, pwc, ps, rw, m2r;
    logic [1:0] a, b;
    logic [3:0] op;
    mreq = 1'b0; mwe = 1'b0; io = 1'b0; irw = 1'b0; pcw = 1'b0;
    pwc = 1'b0; ps = 1'b0; rw = 1'b0; m2r = 1'b0;
    a = 2'b00; b = 2'b00; op = 4'b0000;
    case (s)
      FETCH:  begin mreq = 1'b1; b = 2'b01; irw = r; pcw = r; end
      DECODE: begin a = 2'b10; b = 2'b11; end
      EXEC_R: begin a = 2'b01; b = 2'b00; op = 4'b0010; end
      EXEC_I: begin a = 2'b01; b = 2'b10; op = 4'b0011; end
      ADDR:   begin a = 2'b01; b = 2'b10; end
      MEM_RD: begin mreq = 1'b1; io = 1'b1; end
      MEM_WR: begin mreq = 1'b1; io = 1'b1; mwe = 1'b1; end
      WB_ALU: begin rw = 1'b1; end
      WB_MEM: begin rw = 1'b1; m2r = 1'b1; end
      BRANCH: begin a = 2'b01; b = 2'b00; op = 4'b0001; pwc = 1'b1; ps = 1'b1; end
      default: ;
    endcase
    return {mreq, mwe, io, irw, pcw, pwc, ps, a, b, op, rw, m2r};
  endfunction

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Driver: one clock cycle. Called just after a rising edge.
  task automatic cyc(input logic rst, input logic [6:0] opc, input logic rdy,
                     input logic [3:0] exp_s, input logic inc);
    logic [W-1:0] e;
    logic [W-1:0] got;
    RESET = rst;
    opcode = opc;
    mem_ready = rdy;
    if (rst) exp_q.push_back('0);
    else     exp_q.push_back({exp_s, strobes(exp_s, rdy)});
    @(negedge CLK);
    step++;
    got = obs;
    e = exp_q.pop_front();
    checks++;
    assert (got === e) else begin
      fails++;
      $error("FAIL step %0d outputs {state,strobes}: got %h expected %h", step, got, e);
    end
    checks++;
    assert (retired === exp_retired) else begin
      fails++;
      $error("FAIL step %0d retired: got %0d expected %0d", step, retired, exp_retired);
    end
    checks++;
    assert (illegal === exp_illegal) else begin
      fails++;
      $error("FAIL step %0d illegal: got %b expected %b", step, illegal, exp_illegal);
    end
    @(posedge CLK);
    #1;
    if (rst) begin
      exp_retired = 4'd0;
      exp_illegal = 1'b0;
    end else if (inc) begin
      exp_retired = exp_retired + 4'd1;
    end
  endtask

  task automatic alu_inst(input logic [6:0] opc, input logic [3:0] ex);
    cyc(1'b0, opc, 1'b1,      FETCH,  1'b0);
    cyc(1'b0, opc, rnd_bit(), DECODE, 1'b0);
    cyc(1'b0, opc, rnd_bit(), ex,     1'b0);
    cyc(1'b0, opc, rnd_bit(), WB_ALU, 1'b1);
  endtask

  // stimulus
  initial begin
    checks = 0;
    fails = 0;
    step = 0;
    exp_retired = 4'd0;
    exp_illegal = 1'b0;
    RESET = 1'b1;
    opcode = 7'd0;
    mem_ready = 1'b0;
    @(posedge CLK);
    #1;

    // reset held two cycles, outputs forced low
    cyc(1'b1, 7'd0, 1'b1, FETCH, 1'b0);
    cyc(1'b1, 7'd0, 1'b1, FETCH, 1'b0);

    // R-type then branch, zero-wait: 0,1,2,7,0,1,9
    alu_inst(OP_R, EXEC_R);
    cyc(1'b0, OP_B, 1'b1,      FETCH,  1'b0);
    cyc(1'b0, OP_B, rnd_bit(), DECODE, 1'b0);
    cyc(1'b0, OP_B, rnd_bit(), BRANCH, 1'b1);

    // load with two MEM_RD wait cycles: 0,1,4,5,5,5,8 (retired=2 checked at FETCH)
    cyc(1'b0, OP_L, 1'b1,      FETCH,  1'b0);
    cyc(1'b0, OP_L, rnd_bit(), DECODE, 1'b0);
    cyc(1'b0, OP_L, rnd_bit(), ADDR,   1'b0);
    cyc(1'b0, OP_L, 1'b0,      MEM_RD, 1'b0);
    cyc(1'b0, OP_L, 1'b0,      MEM_RD, 1'b0);
    cyc(1'b0, OP_L, 1'b1,      MEM_RD, 1'b0);
    cyc(1'b0, OP_L, rnd_bit(), WB_MEM, 1'b1);

    // store with three FETCH wait cycles and one MEM_WR wait
    for (int i = 0; i < 3; i++) cyc(1'b0, OP_S, 1'b0, FETCH, 1'b0);
    cyc(1'b0, OP_S, 1'b1,      FETCH,  1'b0);
    cyc(1'b0, OP_S, rnd_bit(), DECODE, 1'b0);
    cyc(1'b0, OP_S, rnd_bit(), ADDR,   1'b0);
    cyc(1'b0, OP_S, 1'b0,      MEM_WR, 1'b0);
    cyc(1'b0, OP_S, 1'b1,      MEM_WR, 1'b1);

    // I-type
    alu_inst(OP_I, EXEC_I);

    // illegal opcode traps and holds until reset
    cyc(1'b0, OP_BAD, 1'b1,      FETCH,  1'b0);
    cyc(1'b0, OP_BAD, rnd_bit(), DECODE, 1'b0);
    exp_illegal = 1'b1;
    for (int i = 0; i < 4; i++) cyc(1'b0, OP_BAD, rnd_bit(), TRAP, 1'b0);
    cyc(1'b1, OP_BAD, 1'b1, FETCH, 1'b0);
    cyc(1'b0, OP_R,   1'b0, FETCH, 1'b0);

    // counter wrap: 15 R-types reach 15, the 16th wraps to 0
    cyc(1'b1, OP_R, 1'b0, FETCH, 1'b0);
    for (int k = 0; k < 16; k++) alu_inst(OP_R, EXEC_R);

    // reset in MEM_RD abandons the load, then a clean fetch
    cyc(1'b0, OP_L, 1'b1,      FETCH,  1'b0);
    cyc(1'b0, OP_L, rnd_bit(), DECODE, 1'b0);
    cyc(1'b0, OP_L, rnd_bit(), ADDR,   1'b0);
    cyc(1'b0, OP_L, 1'b0,      MEM_RD, 1'b0);
    cyc(1'b1, OP_L, 1'b1,      MEM_RD, 1'b0);
    cyc(1'b0, OP_L, 1'b1,      FETCH,  1'b0);
    cyc(1'b0, OP_L, rnd_bit(), DECODE, 1'b0);

    // final report
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
